// File: rtl/reg_file_arb_pkg.sv
// rtl/reg_file_arb_pkg.sv - state and grant encodings for the reg_file write arbiter
package reg_file_arb_pkg;

  typedef enum logic {
    INIT,
    ARB
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_REQ0,
    GNT_REQ1
  } grant_t;

endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// rtl/riscv_32i_defs_pkg.sv - RV32I architectural constants and register types
package riscv_32i_defs_pkg;

  localparam int XLEN = 32;

  // x0 reads as zero and ignores writes
  localparam logic [4:0] X0 = 5'd0;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_arb_assert.sv
// rtl/reg_file_arb_assert.sv - invariant checker for the reg_file write arbiter
module reg_file_arb_assert #(
  parameter int ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  req0_ready,
  input logic                  req1_ready,
  input logic                  wr_en,
  input logic [ADDR_WIDTH-1:0] wr_reg
);

  // At most one requester is accepted in any cycle
  ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  // The hard-wired zero register is never written
  no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> (wr_reg != '0));

endmodule

// File: rtl/reg_file_arb_grant.sv
// rtl/reg_file_arb_grant.sv - combinational grant select for the reg_file write port
module reg_file_arb_grant
  import reg_file_arb_pkg::*;
(
  input  arb_state_t state,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic       rr_last,
  output grant_t     grant
);

  // Only ARB grants; a contested cycle goes to the requester not granted last.
  // Holding rr_last at 0 turns this into fixed priority with req1 on top.
  always_comb begin
    grant = GNT_NONE;
    if (state == ARB) begin
      if (req0_valid && req1_valid) begin
        grant = rr_last ? GNT_REQ0 : GNT_REQ1;
      end else if (req1_valid) begin
        grant = GNT_REQ1;
      end else if (req0_valid) begin
        grant = GNT_REQ0;
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// rtl/reg_file_wr_arbiter.sv - zero-sweep then two-way arbitration of the reg_file write port (option: REG_FILE_ARB_RR_EN)
module reg_file_wr_arbiter
  import riscv_32i_defs_pkg::*;
  import reg_file_arb_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_reg,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(X0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  arb_state_t            state;
  logic [ADDR_WIDTH-1:0] init_idx;
  logic                  rr_last;
  grant_t                grant;

  reg_file_arb_grant u_grant (
    .state      (state),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .rr_last    (rr_last),
    .grant      (grant)
  );

  assign req0_ready = (grant == GNT_REQ0);
  assign req1_ready = (grant == GNT_REQ1);

`ifdef REG_FILE_ARB_RR_EN
  // Remember which requester won the most recent transfer (1 = req1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b0;
    end else if (grant == GNT_REQ1) begin
      rr_last <= 1'b1;
    end else if (grant == GNT_REQ0) begin
      rr_last <= 1'b0;
    end
  end
`else
  assign rr_last = 1'b0;
`endif

  // Sweep x1..x(NUM_REGS-1) to zero, then register the granted write each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_idx  <= ADDR_WIDTH'(1);
      wr_en     <= 1'b0;
      wr_reg    <= ZERO_IDX;
      wr_data   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          wr_en    <= 1'b1;
          wr_reg   <= init_idx;
          wr_data  <= '0;
          init_idx <= init_idx + 1'b1;
          if (init_idx == LAST_IDX) begin
            state     <= ARB;
            init_done <= 1'b1;
          end
        end
        ARB: begin
          // x0 writes are accepted but never strobed into the file
          if (grant == GNT_REQ1) begin
            wr_en   <= (req1_reg != ZERO_IDX);
            wr_reg  <= req1_reg;
            wr_data <= req1_data;
          end else if (grant == GNT_REQ0) begin
            wr_en   <= (req0_reg != ZERO_IDX);
            wr_reg  <= req0_reg;
            wr_data <= req0_data;
          end else begin
            wr_en <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// tb/tb_reg_file_wr_arbiter.sv - directed vector bench for reg_file_wr_arbiter
module tb_reg_file_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        init_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_wr_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .init_done  (init_done)
  );

  reg_file_arb_assert #(.ADDR_WIDTH(5)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg)
  );

  typedef struct {
    string       name;
    logic        v0;
    logic [4:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  r1;
    logic [31:0] d1;
    logic        rdy0;
    logic        rdy1;
    logic        en;
    logic [4:0]  reg_x;
    logic [31:0] data_x;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n,
                              input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                              input logic rdy0, input logic rdy1,
                              input logic en, input logic [4:0] rx, input logic [31:0] dx);
    vec_t v;
    v.name = n; v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.en = en; v.reg_x = rx; v.data_x = dx;
    return v;
  endfunction

  initial begin
    logic        p0, p1, rr_m, g0_sel, g1_sel;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_en;
    int          g0_cnt, g1_cnt;

    // Table fill: ARB-phase single-cycle vectors, entered after the x5 load write.
    vecs[0] = mk("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 32'hDEAD_BEEF);
    vecs[1] = mk("req0_only", 1, 7, 32'h11, 0, 0, 0, 1, 0, 1, 5'd7, 32'h11);
    vecs[2] = mk("req1_only", 0, 0, 0, 1, 8, 32'h22, 0, 1, 1, 5'd8, 32'h22);
`ifdef REG_FILE_ARB_RR_EN
    vecs[3] = mk("both_a", 1, 3, 32'h1, 1, 4, 32'h2, 1, 0, 1, 5'd3, 32'h1);
    vecs[4] = mk("both_b", 1, 3, 32'h1, 1, 4, 32'h2, 0, 1, 1, 5'd4, 32'h2);
    vecs[5] = mk("both_c", 1, 3, 32'h1, 1, 4, 32'h2, 1, 0, 1, 5'd3, 32'h1);
`else
    vecs[3] = mk("both_a", 1, 3, 32'h1, 1, 4, 32'h2, 0, 1, 1, 5'd4, 32'h2);
    vecs[4] = mk("both_b", 1, 3, 32'h1, 1, 4, 32'h2, 0, 1, 1, 5'd4, 32'h2);
    vecs[5] = mk("both_c", 1, 3, 32'h1, 1, 4, 32'h2, 0, 1, 1, 5'd4, 32'h2);
`endif
    vecs[6] = mk("req0_x0", 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 5'd0, 32'hFFFF_FFFF);
    vecs[7] = mk("req1_x0", 0, 0, 0, 1, 0, 32'h5, 0, 1, 0, 5'd0, 32'h5);
    vecs[8] = mk("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h5);

    // Reset with a load request already waiting
    rst_n = 1'b0;
    req0_valid = 0; req0_reg = 0; req0_data = 0;
    req1_valid = 1; req1_reg = 5'd5; req1_data = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_reg", wr_reg, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);

    // Zero sweep, pending load must wait until ARB
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk); #1;
      check($sformatf("sweep_en_%0d", i), wr_en, 1);
      check($sformatf("sweep_reg_%0d", i), wr_reg, i);
      check($sformatf("sweep_data_%0d", i), wr_data, 0);
      check($sformatf("sweep_done_%0d", i), init_done, (i == 31));
      check($sformatf("sweep_rdy1_%0d", i), req1_ready, (i == 31));
    end
    @(posedge clk); #1;
    check("load_en", wr_en, 1);
    check("load_reg", wr_reg, 5);
    check("load_data", wr_data, 32'hDEAD_BEEF);
    req1_valid = 0;

    // Table-driven ARB vectors
    for (int k = 0; k < 9; k++) begin
      req0_valid = vecs[k].v0; req0_reg = vecs[k].r0; req0_data = vecs[k].d0;
      req1_valid = vecs[k].v1; req1_reg = vecs[k].r1; req1_data = vecs[k].d1;
      #1;
      check({vecs[k].name, "_rdy0"}, req0_ready, vecs[k].rdy0);
      check({vecs[k].name, "_rdy1"}, req1_ready, vecs[k].rdy1);
      @(posedge clk); #1;
      check({vecs[k].name, "_en"}, wr_en, vecs[k].en);
      check({vecs[k].name, "_reg"}, wr_reg, vecs[k].reg_x);
      check({vecs[k].name, "_data"}, wr_data, vecs[k].data_x);
    end

    // Random traffic against a reference model; requests held until accepted
    p0 = 0; p1 = 0; rr_m = 1'b1; exp_reg = 5'd0; exp_data = 32'h5;
    g0_cnt = 0; g1_cnt = 0;
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 300; c++) begin
      if (!p0 && ($urandom_range(0, 3) != 0)) begin
        p0 = 1; req0_reg = 5'($urandom_range(0, 31)); req0_data = $urandom;
      end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin
        p1 = 1; req1_reg = 5'($urandom_range(0, 31)); req1_data = $urandom;
      end
      req0_valid = p0; req1_valid = p1;
`ifdef REG_FILE_ARB_RR_EN
      g1_sel = p1 && (!p0 || !rr_m);
`else
      g1_sel = p1;
`endif
      g0_sel = p0 && !g1_sel;
      #1;
      check($sformatf("rnd_rdy_%0d", c), {req0_ready, req1_ready}, {g0_sel, g1_sel});
      exp_en = 0;
      if (g1_sel) begin
        exp_en = (req1_reg != 0); exp_reg = req1_reg; exp_data = req1_data;
        rr_m = 1; p1 = 0; g1_cnt++;
      end else if (g0_sel) begin
        exp_en = (req0_reg != 0); exp_reg = req0_reg; exp_data = req0_data;
        rr_m = 0; p0 = 0; g0_cnt++;
      end
      @(posedge clk); #1;
      check($sformatf("rnd_en_%0d", c), wr_en, exp_en);
      check($sformatf("rnd_reg_%0d", c), wr_reg, exp_reg);
      check($sformatf("rnd_data_%0d", c), wr_data, exp_data);
      req0_valid = 0; req1_valid = 0;
    end
    check("rnd_req0_bin", (g0_cnt > 0), 1);
    check("rnd_req1_bin", (g1_cnt > 0), 1);

    // Reset dropped part-way through the sweep
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      check($sformatf("sweep2_reg_%0d", i), wr_reg, i);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_en", wr_en, 0);
    check("midrst_reg", wr_reg, 0);
    check("midrst_done", init_done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_en", wr_en, 1);
    check("restart_reg", wr_reg, 1);
    repeat (29) @(posedge clk);
    #1;
    check("restart_done_early", init_done, 0);
    check("restart_reg30", wr_reg, 30);
    @(posedge clk); #1;
    check("restart_done", init_done, 1);
    check("restart_reg31", wr_reg, 31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
